// File: rtl/multi_channel_clock_gate_ctrl_if.sv
// multi_channel_clock_gate_ctrl_if: request/status bundle for the multi-channel clock gate controller
interface multi_channel_clock_gate_ctrl_if #(
  parameter int NCH   = 4,
  parameter int TMO_W = 4,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]       trig;
  logic [NCH-1:0]       force_on;
  logic [TMO_W-1:0]     idle_timeout;
  logic                 stat_clr;
  logic [NCH-1:0]       gated_clk;
  logic [NCH-1:0]       clk_en;
  logic [2*NCH-1:0]     state;
  logic [NCH-1:0]       wake_evt;
  logic [NCH*CNT_W-1:0] active_cycles;
  logic [CNT_W-1:0]     total_cycles;
  modport master (
    output trig, force_on, idle_timeout, stat_clr,
    input  gated_clk, clk_en, state, wake_evt, active_cycles, total_cycles
  );
  modport slave (
    input  trig, force_on, idle_timeout, stat_clr,
    output gated_clk, clk_en, state, wake_evt, active_cycles, total_cycles
  );
endinterface

// File: rtl/multi_channel_clock_gate_ctrl.sv
// multi_channel_clock_gate_ctrl: per-channel idle-timeout FSMs driving latch-based glitch-free clock gates
module multi_channel_clock_gate_ctrl #(
  parameter int NCH   = 4,
  parameter int TMO_W = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  multi_channel_clock_gate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, WAIT = 2'b11, SLEEP = 2'b10} st_e;
  localparam logic [CNT_W-1:0] CMAX = '1;
  st_e              st_q  [NCH];
  st_e              st_d  [NCH];
  logic [TMO_W-1:0] tmr_q [NCH];
  logic [TMO_W-1:0] tmr_d [NCH];
  logic [CNT_W-1:0] act_q [NCH];
  logic [CNT_W-1:0] act_d [NCH];
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [NCH-1:0]   en_q, en_d, wake_q, wake_d, en_lat, req;
  assign req = bus.trig | bus.force_on;
  always_comb begin
    tot_d = bus.stat_clr ? '0 : tot_q + CNT_W'(tot_q != CMAX);
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      tmr_d[i]  = tmr_q[i];
      en_d[i]   = st_q[i] == ACTIVE || st_q[i] == WAIT;
      wake_d[i] = st_q[i] == SLEEP && req[i];
      act_d[i]  = bus.stat_clr ? '0 : act_q[i] + CNT_W'(en_q[i] && act_q[i] != CMAX);
      case (st_q[i])
        IDLE:   st_d[i] = req[i] ? ACTIVE : IDLE;
        ACTIVE: if (!req[i]) begin
          st_d[i]  = WAIT;
          tmr_d[i] = bus.idle_timeout;
        end
        WAIT:   if (req[i]) st_d[i] = ACTIVE;
                else if (tmr_q[i] != '0) tmr_d[i] = tmr_q[i] - TMO_W'(1);
                else st_d[i] = SLEEP;
        default: st_d[i] = req[i] ? ACTIVE : SLEEP;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q   <= '{default: IDLE};
      tmr_q  <= '{default: '0};
      act_q  <= '{default: '0};
      tot_q  <= '0;
      en_q   <= '0;
      wake_q <= '0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      act_q  <= act_d;
      tot_q  <= tot_d;
      en_q   <= en_d;
      wake_q <= wake_d;
    end
  // enable only moves while clk is low, so gated_clk never sees a mid-high-phase change
  always_latch
    if (rst) en_lat <= '0;
    else if (!clk) en_lat <= en_q;
  assign bus.gated_clk    = {NCH{clk}} & en_lat;
  assign bus.clk_en       = en_q;
  assign bus.wake_evt     = wake_q;
  assign bus.total_cycles = tot_q;
  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign bus.state[2*c +: 2]             = st_q[c];
    assign bus.active_cycles[c*CNT_W +: CNT_W] = act_q[c];
  end
endmodule

// File: tb/tb_multi_channel_clock_gate_ctrl.sv
// tb_multi_channel_clock_gate_ctrl: scoreboard-driven directed bench for the multi-channel clock gate
module tb_multi_channel_clock_gate_ctrl;
  localparam int NCH = 4, TMO_W = 4, CNT_W = 16, MAXC = (1 << CNT_W) - 1;
  typedef struct packed {
    logic [2*NCH-1:0]     st;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       wk;
    logic [CNT_W-1:0]     tot;
    logic [NCH*CNT_W-1:0] act;
  } exp_t;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  bit mon_en = 0;
  exp_t sb[$];
  logic [1:0] m_st [NCH];
  int m_tmr [NCH];
  int m_act [NCH];
  int m_tot;
  logic [NCH-1:0] m_en, m_wk, g_prev = '0;
  time t_rise [NCH];
  always #5 clk = ~clk;
  multi_channel_clock_gate_ctrl_if #(.NCH(NCH), .TMO_W(TMO_W), .CNT_W(CNT_W)) bus ();
  multi_channel_clock_gate_ctrl_if #(.NCH(NCH), .TMO_W(TMO_W), .CNT_W(4)) bus4 ();
  multi_channel_clock_gate_ctrl #(.NCH(NCH), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  multi_channel_clock_gate_ctrl #(.NCH(NCH), .TMO_W(TMO_W), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = 2'b00;
      m_tmr[i] = 0;
      m_act[i] = 0;
    end
    m_en = '0;
    m_wk = '0;
    m_tot = 0;
  endtask
  task automatic model_edge();
    logic req;
    if (rst) begin
      model_reset();
      return;
    end
    m_tot = bus.stat_clr ? 0 : (m_tot == MAXC ? MAXC : m_tot + 1);
    for (int i = 0; i < NCH; i++) begin
      req = bus.trig[i] | bus.force_on[i];
      m_act[i] = bus.stat_clr ? 0 : ((m_en[i] && m_act[i] < MAXC) ? m_act[i] + 1 : m_act[i]);
      m_en[i] = m_st[i] == 2'b01 || m_st[i] == 2'b11;
      m_wk[i] = m_st[i] == 2'b10 && req;
      if (m_st[i] == 2'b00) m_st[i] = req ? 2'b01 : 2'b00;
      else if (m_st[i] == 2'b01) begin
        if (!req) begin
          m_st[i] = 2'b11;
          m_tmr[i] = int'(bus.idle_timeout);
        end
      end else if (m_st[i] == 2'b11) begin
        if (req) m_st[i] = 2'b01;
        else if (m_tmr[i] > 0) m_tmr[i]--;
        else m_st[i] = 2'b10;
      end else m_st[i] = req ? 2'b01 : 2'b10;
    end
  endtask
  function automatic exp_t pack();
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      e.st[2*i +: 2] = m_st[i];
      e.act[i*CNT_W +: CNT_W] = CNT_W'(m_act[i]);
    end
    e.en = m_en;
    e.wk = m_wk;
    e.tot = CNT_W'(m_tot);
    return e;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      exp_t e;
      logic [NCH-1:0] pre;
      pre = m_en;
      model_edge();
      sb.push_back(pack());
      @(posedge clk);
      #1;
      chk("gated_high", 64'(bus.gated_clk), 64'(pre));
      @(negedge clk);
      if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("state", 64'(bus.state), 64'(e.st));
        chk("clk_en", 64'(bus.clk_en), 64'(e.en));
        chk("wake_evt", 64'(bus.wake_evt), 64'(e.wk));
        chk("total_cycles", 64'(bus.total_cycles), 64'(e.tot));
        chk("active_cycles", 64'(bus.active_cycles), 64'(e.act));
      end
    end
  endtask
  always @(bus.gated_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (bus.gated_clk[i] === 1'b1 && g_prev[i] === 1'b0) t_rise[i] = $time;
      if (bus.gated_clk[i] === 1'b0 && g_prev[i] === 1'b1 && mon_en)
        chk("pulse_width", 64'($time - t_rise[i]), 64'd5);
    end
    g_prev = bus.gated_clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.trig = '0;
    bus.force_on = '0;
    bus.idle_timeout = 4'd3;
    bus.stat_clr = 1'b0;
    bus4.trig = '0;
    bus4.force_on = 4'b0001;
    bus4.idle_timeout = '0;
    bus4.stat_clr = 1'b0;
    model_reset();
    @(negedge clk);
    tick(2);
    rst = 0;
    tick(2);
    bus.trig[0] = 1'b1;
    tick(3);
    bus.trig[0] = 1'b0;
    tick(8);
    chk("ch0_active_cnt", 64'(bus.active_cycles[CNT_W-1:0]), 64'd7);
    chk("ch0_sleep", 64'(bus.state[1:0]), 64'(2'b10));
    chk("ch123_idle", 64'(bus.state[7:2]), 64'd0);
    bus.trig[1] = 1'b1;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      bus.trig[1] = k >= 2;
      tick(1);
      chk("ch1_en_held", 64'(bus.clk_en[1]), 64'd1);
      chk("ch1_no_wake", 64'(bus.wake_evt[1]), 64'd0);
    end
    bus.trig[1] = 1'b0;
    tick(8);
    bus.idle_timeout = 4'd0;
    bus.trig[2] = 1'b1;
    tick(1);
    bus.trig[2] = 1'b0;
    tick(1);
    chk("ch2_wait", 64'(bus.state[5:4]), 64'(2'b11));
    tick(1);
    chk("ch2_sleep_t0", 64'(bus.state[5:4]), 64'(2'b10));
    tick(1);
    bus.trig[2] = 1'b1;
    tick(1);
    chk("ch2_wake_act", 64'(bus.state[5:4]), 64'(2'b01));
    chk("ch2_wake_hi", 64'(bus.wake_evt[2]), 64'd1);
    bus.trig[2] = 1'b0;
    tick(1);
    chk("ch2_wake_lo", 64'(bus.wake_evt[2]), 64'd0);
    tick(3);
    bus.idle_timeout = 4'd3;
    bus.force_on[3] = 1'b1;
    tick(10);
    bus.stat_clr = 1'b1;
    tick(1);
    chk("clr_total", 64'(bus.total_cycles), 64'd0);
    chk("clr_active", 64'(bus.active_cycles), 64'd0);
    bus.stat_clr = 1'b0;
    tick(9);
    chk("ch3_forced", 64'(bus.state[7:6]), 64'(2'b01));
    bus.force_on[3] = 1'b0;
    tick(6);
    bus.trig = 4'b1011;
    tick(2);
    bus.trig = '0;
    tick(6);
    mon_en = 1;
    for (int k = 0; k < 40; k++) begin
      int off;
      off = int'($urandom_range(1, 9));
      if (off == 5) off = 6;
      #(off);
      bus.trig = NCH'($urandom);
      @(negedge clk);
    end
    mon_en = 0;
    bus.trig = '1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_gated", 64'(bus.gated_clk), 64'hf);
    rst = 1;
    #1;
    chk("rst_gated", 64'(bus.gated_clk), 64'd0);
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_total", 64'(bus.total_cycles), 64'd0);
    chk("rst_active", 64'(bus.active_cycles), 64'd0);
    chk("rst_en", 64'(bus.clk_en), 64'd0);
    model_reset();
    @(negedge clk);
    bus.trig = '0;
    tick(2);
    rst = 0;
    tick(3);
    bus4.stat_clr = 1'b1;
    @(negedge clk);
    bus4.stat_clr = 1'b0;
    repeat (14) @(negedge clk);
    chk("sat_total_14", 64'(bus4.total_cycles), 64'd14);
    chk("sat_active_14", 64'(bus4.active_cycles[3:0]), 64'd14);
    repeat (6) @(negedge clk);
    chk("sat_total_15", 64'(bus4.total_cycles), 64'd15);
    chk("sat_active_15", 64'(bus4.active_cycles[3:0]), 64'd15);
    repeat (3) @(negedge clk);
    chk("sat_total_hold", 64'(bus4.total_cycles), 64'd15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
